// File: rtl/aes_pkg.sv
// aes_pkg: shared widths, requester ids and the SubBytes issue tag
package aes_pkg;
  localparam int DATA_LEN = 128;
  localparam int WORD_LEN = 32;
  typedef enum logic {REQ_RND = 1'b0, REQ_KEY = 1'b1} req_e;
  typedef struct packed {
    logic valid;
    req_e id;
  } tag_t;
endpackage

// File: rtl/aes_subbytes_arbiter_if.sv
// aes_subbytes_arbiter_if: round/key request-result handshakes plus the SubBytes issue/return bus
interface aes_subbytes_arbiter_if;
  import aes_pkg::*;
  logic                rnd_valid_in, rnd_ready_out, rnd_valid_out, rnd_ready_in;
  logic [DATA_LEN-1:0] rnd_data_in, rnd_data_out;
  logic                key_valid_in, key_ready_out, key_valid_out, key_ready_in;
  logic [WORD_LEN-1:0] key_data_in, key_data_out;
  logic                sb_valid, sb_valid_ret;
  logic [DATA_LEN-1:0] sb_data, sb_data_ret;
  logic                busy_out, err_out;
  modport slave (
    input  rnd_valid_in, rnd_data_in, rnd_ready_in, key_valid_in, key_data_in, key_ready_in,
           sb_valid_ret, sb_data_ret,
    output rnd_ready_out, rnd_valid_out, rnd_data_out, key_ready_out, key_valid_out, key_data_out,
           sb_valid, sb_data, busy_out, err_out
  );
  modport master (
    output rnd_valid_in, rnd_data_in, rnd_ready_in, key_valid_in, key_data_in, key_ready_in,
           sb_valid_ret, sb_data_ret,
    input  rnd_ready_out, rnd_valid_out, rnd_data_out, key_ready_out, key_valid_out, key_data_out,
           sb_valid, sb_data, busy_out, err_out
  );
endinterface

// File: rtl/aes_sb_tag_pipe.sv
// aes_sb_tag_pipe: SBOX_LAT-deep tag shift register aligned with the SubBytes return
module aes_sb_tag_pipe
  import aes_pkg::*;
#(
  parameter int SBOX_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  tag_t tag_i,
  output tag_t tag_o
);
  tag_t pipe_q [SBOX_LAT];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SBOX_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= tag_i;
      for (int i = 1; i < SBOX_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end
  assign tag_o = pipe_q[SBOX_LAT-1];
endmodule

// File: rtl/aes_subbytes_arbiter.sv
// aes_subbytes_arbiter: round-robin sharing of one SubBytes unit between round and key paths
module aes_subbytes_arbiter
  import aes_pkg::*;
#(
  parameter int SBOX_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  aes_subbytes_arbiter_if.slave bus
);
  logic                out_rnd_q, out_rnd_d, out_key_q, out_key_d;
  logic                rnd_vo_q, rnd_vo_d, key_vo_q, key_vo_d, err_q, err_d;
  logic [DATA_LEN-1:0] rnd_data_q, rnd_data_d;
  logic [WORD_LEN-1:0] key_data_q, key_data_d;
  req_e                last_q, last_d;
  logic                elig_rnd, elig_key, gnt_rnd, gnt_key, hit_rnd, hit_key, hs_rnd, hs_key;
  tag_t                tag_in, tag_ret;
  assign elig_rnd = bus.rnd_valid_in & ~out_rnd_q;
  assign elig_key = bus.key_valid_in & ~out_key_q;
  // a tie goes to whoever was not granted last
  assign gnt_rnd  = elig_rnd & (~elig_key | last_q == REQ_KEY);
  assign gnt_key  = elig_key & ~gnt_rnd;
  assign tag_in   = '{valid: gnt_rnd | gnt_key, id: gnt_key ? REQ_KEY : REQ_RND};
  aes_sb_tag_pipe #(.SBOX_LAT(SBOX_LAT)) u_tag_pipe (
    .clk  (clk),
    .reset(reset),
    .tag_i(tag_in),
    .tag_o(tag_ret)
  );
  assign hit_rnd = bus.sb_valid_ret & tag_ret.valid & tag_ret.id == REQ_RND;
  assign hit_key = bus.sb_valid_ret & tag_ret.valid & tag_ret.id == REQ_KEY;
  assign hs_rnd  = rnd_vo_q & bus.rnd_ready_in;
  assign hs_key  = key_vo_q & bus.key_ready_in;
  always_comb begin
    out_rnd_d  = gnt_rnd | (out_rnd_q & ~hs_rnd);
    out_key_d  = gnt_key | (out_key_q & ~hs_key);
    rnd_vo_d   = hit_rnd | (rnd_vo_q & ~hs_rnd);
    key_vo_d   = hit_key | (key_vo_q & ~hs_key);
    rnd_data_d = hit_rnd ? bus.sb_data_ret : rnd_data_q;
    key_data_d = hit_key ? bus.sb_data_ret[WORD_LEN-1:0] : key_data_q;
    last_d     = tag_in.valid ? tag_in.id : last_q;
    err_d      = err_q | (tag_ret.valid ^ bus.sb_valid_ret);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_rnd_q  <= 1'b0;
      out_key_q  <= 1'b0;
      rnd_vo_q   <= 1'b0;
      key_vo_q   <= 1'b0;
      rnd_data_q <= '0;
      key_data_q <= '0;
      last_q     <= REQ_KEY;
      err_q      <= 1'b0;
    end else begin
      out_rnd_q  <= out_rnd_d;
      out_key_q  <= out_key_d;
      rnd_vo_q   <= rnd_vo_d;
      key_vo_q   <= key_vo_d;
      rnd_data_q <= rnd_data_d;
      key_data_q <= key_data_d;
      last_q     <= last_d;
      err_q      <= err_d;
    end
  end
  assign bus.rnd_ready_out = gnt_rnd;
  assign bus.key_ready_out = gnt_key;
  assign bus.rnd_valid_out = rnd_vo_q;
  assign bus.key_valid_out = key_vo_q;
  assign bus.rnd_data_out  = rnd_data_q;
  assign bus.key_data_out  = key_data_q;
  assign bus.sb_valid      = tag_in.valid;
  assign bus.sb_data       = gnt_rnd ? bus.rnd_data_in : gnt_key ? DATA_LEN'(bus.key_data_in) : '0;
  assign bus.busy_out      = out_rnd_q | out_key_q;
  assign bus.err_out       = err_q;
endmodule

// File: tb/tb_aes_subbytes_arbiter.sv
// tb_aes_subbytes_arbiter: directed checks of the SubBytes arbiter with a 1-cycle SubBytes stand-in
module tb_aes_subbytes_arbiter;
  import aes_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic inj = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic               sbv_q;
  logic [DATA_LEN-1:0] sbd_q;
  aes_subbytes_arbiter_if bus ();
  aes_subbytes_arbiter #(.SBOX_LAT(1)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [7:0] sb8(input logic [7:0] b);
    case (b)
      8'h00:   return 8'h63;
      8'h01:   return 8'h7c;
      8'h10:   return 8'hca;
      8'h53:   return 8'hed;
      8'hff:   return 8'h16;
      default: return ~b;
    endcase
  endfunction
  function automatic logic [DATA_LEN-1:0] sb128(input logic [DATA_LEN-1:0] d);
    logic [DATA_LEN-1:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sb8(d[8*i +: 8]);
    return r;
  endfunction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sbv_q <= 1'b0;
      sbd_q <= '0;
    end else begin
      sbv_q <= bus.sb_valid;
      sbd_q <= sb128(bus.sb_data);
    end
  end
  assign bus.sb_valid_ret = sbv_q | inj;
  assign bus.sb_data_ret  = sbd_q;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic apply_reset();
    bus.rnd_valid_in = 0; bus.key_valid_in = 0;
    bus.rnd_data_in = '0; bus.key_data_in = '0;
    bus.rnd_ready_in = 1; bus.key_ready_in = 1;
    inj = 0;
    reset = 1;
    cyc();
    cyc();
    reset = 0;
  endtask
  task automatic test_reset();
    apply_reset();
    #1;
    n_checks++;
    if ({bus.rnd_ready_out, bus.key_ready_out, bus.rnd_valid_out, bus.key_valid_out, bus.sb_valid, bus.busy_out, bus.err_out} !== 7'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 0000000", {bus.rnd_ready_out, bus.key_ready_out, bus.rnd_valid_out, bus.key_valid_out, bus.sb_valid, bus.busy_out, bus.err_out});
    end
    n_checks++;
    if ({bus.sb_data, bus.rnd_data_out, bus.key_data_out} !== '0) begin
      n_fail++; $display("FAIL reset_data: got sb=%h rnd=%h key=%h expected 0", bus.sb_data, bus.rnd_data_out, bus.key_data_out);
    end
  endtask
  task automatic test_round_only();
    apply_reset();
    cyc();
    bus.rnd_valid_in = 1; bus.rnd_data_in = '0;
    #1;
    n_checks++;
    if ({bus.rnd_ready_out, bus.sb_valid} !== 2'b11 || bus.sb_data !== '0) begin
      n_fail++; $display("FAIL rnd_issue: got rdy=%b sbv=%b sbd=%h expected 1 1 0", bus.rnd_ready_out, bus.sb_valid, bus.sb_data);
    end
    cyc();
    bus.rnd_valid_in = 0;
    #1;
    n_checks++;
    if ({bus.rnd_valid_out, bus.busy_out} !== 2'b01) begin
      n_fail++; $display("FAIL rnd_inflight: got vo=%b busy=%b expected 0 1", bus.rnd_valid_out, bus.busy_out);
    end
    cyc();
    n_checks++;
    if (bus.rnd_valid_out !== 1'b1 || bus.rnd_data_out !== {16{8'h63}} || bus.busy_out !== 1'b1) begin
      n_fail++; $display("FAIL rnd_result: got vo=%b data=%h busy=%b expected 1 6363..63 1", bus.rnd_valid_out, bus.rnd_data_out, bus.busy_out);
    end
    cyc();
    n_checks++;
    if ({bus.rnd_valid_out, bus.busy_out, bus.err_out} !== 3'b000) begin
      n_fail++; $display("FAIL rnd_done: got vo=%b busy=%b err=%b expected 0 0 0", bus.rnd_valid_out, bus.busy_out, bus.err_out);
    end
  endtask
  task automatic test_key_only();
    apply_reset();
    cyc();
    bus.key_valid_in = 1; bus.key_data_in = 32'h00530000;
    #1;
    n_checks++;
    if (bus.key_ready_out !== 1'b1 || bus.sb_data !== 128'h00530000) begin
      n_fail++; $display("FAIL key_issue: got rdy=%b sbd=%h expected 1 00..00530000", bus.key_ready_out, bus.sb_data);
    end
    cyc();
    bus.key_valid_in = 0;
    cyc();
    n_checks++;
    if (bus.key_valid_out !== 1'b1 || bus.key_data_out !== 32'h63ed6363) begin
      n_fail++; $display("FAIL key_result: got vo=%b data=%h expected 1 63ed6363", bus.key_valid_out, bus.key_data_out);
    end
    cyc();
    n_checks++;
    if ({bus.key_valid_out, bus.busy_out} !== 2'b00) begin
      n_fail++; $display("FAIL key_done: got vo=%b busy=%b expected 0 0", bus.key_valid_out, bus.busy_out);
    end
  endtask
  task automatic test_arbitration();
    apply_reset();
    bus.rnd_valid_in = 1; bus.rnd_data_in = {16{8'h01}};
    bus.key_valid_in = 1; bus.key_data_in = 32'h10ff0000;
    #1;
    n_checks++;
    if ({bus.rnd_ready_out, bus.key_ready_out} !== 2'b10 || bus.sb_data !== {16{8'h01}}) begin
      n_fail++; $display("FAIL arb_first: got rnd_rdy=%b key_rdy=%b sbd=%h expected 1 0 0101..01", bus.rnd_ready_out, bus.key_ready_out, bus.sb_data);
    end
    cyc();
    #1;
    n_checks++;
    if ({bus.rnd_ready_out, bus.key_ready_out} !== 2'b01 || bus.sb_data !== 128'h10ff0000) begin
      n_fail++; $display("FAIL arb_second: got rnd_rdy=%b key_rdy=%b sbd=%h expected 0 1 00..10ff0000", bus.rnd_ready_out, bus.key_ready_out, bus.sb_data);
    end
    cyc();
    bus.rnd_valid_in = 0; bus.key_valid_in = 0;
    #1;
    n_checks++;
    if (bus.rnd_valid_out !== 1'b1 || bus.rnd_data_out !== {16{8'h7c}} || bus.key_valid_out !== 1'b0) begin
      n_fail++; $display("FAIL arb_rnd_res: got vo=%b data=%h key_vo=%b expected 1 7c7c..7c 0", bus.rnd_valid_out, bus.rnd_data_out, bus.key_valid_out);
    end
    cyc();
    n_checks++;
    if (bus.key_valid_out !== 1'b1 || bus.key_data_out !== 32'hca166363 || bus.rnd_valid_out !== 1'b0) begin
      n_fail++; $display("FAIL arb_key_res: got vo=%b data=%h rnd_vo=%b expected 1 ca166363 0", bus.key_valid_out, bus.key_data_out, bus.rnd_valid_out);
    end
    cyc();
    bus.rnd_valid_in = 1;
    cyc();
    bus.rnd_valid_in = 0;
    cyc();
    cyc();
    bus.rnd_valid_in = 1; bus.key_valid_in = 1;
    #1;
    n_checks++;
    if ({bus.rnd_ready_out, bus.key_ready_out} !== 2'b01) begin
      n_fail++; $display("FAIL arb_rr: got rnd_rdy=%b key_rdy=%b expected 0 1", bus.rnd_ready_out, bus.key_ready_out);
    end
    cyc();
    bus.rnd_valid_in = 0; bus.key_valid_in = 0;
    cyc();
    cyc();
  endtask
  task automatic test_backpressure();
    apply_reset();
    bus.rnd_ready_in = 0;
    bus.rnd_valid_in = 1; bus.rnd_data_in = '0;
    cyc();
    bus.rnd_data_in = {16{8'hff}};
    cyc();
    for (int i = 0; i < 10; i++) begin
      if (i == 0) begin bus.key_valid_in = 1; bus.key_data_in = '0; end
      if (i == 1) bus.key_valid_in = 0;
      #1;
      n_checks++;
      if (bus.rnd_valid_out !== 1'b1 || bus.rnd_data_out !== {16{8'h63}} || bus.rnd_ready_out !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got vo=%b data=%h rdy=%b expected 1 6363..63 0", i, bus.rnd_valid_out, bus.rnd_data_out, bus.rnd_ready_out);
      end
      if (i == 0) begin
        n_checks++;
        if (bus.key_ready_out !== 1'b1) begin
          n_fail++; $display("FAIL bp_key_acc: got %b expected 1", bus.key_ready_out);
        end
      end
      if (i == 2) begin
        n_checks++;
        if (bus.key_valid_out !== 1'b1 || bus.key_data_out !== 32'h63636363) begin
          n_fail++; $display("FAIL bp_key_res: got vo=%b data=%h expected 1 63636363", bus.key_valid_out, bus.key_data_out);
        end
      end
      cyc();
    end
    bus.rnd_ready_in = 1;
    cyc();
    #1;
    n_checks++;
    if (bus.rnd_valid_out !== 1'b0 || bus.rnd_ready_out !== 1'b1 || bus.sb_data !== {16{8'hff}}) begin
      n_fail++; $display("FAIL bp_release: got vo=%b rdy=%b sbd=%h expected 0 1 ffff..ff", bus.rnd_valid_out, bus.rnd_ready_out, bus.sb_data);
    end
    cyc();
    bus.rnd_valid_in = 0;
    cyc();
    n_checks++;
    if (bus.rnd_valid_out !== 1'b1 || bus.rnd_data_out !== {16{8'h16}}) begin
      n_fail++; $display("FAIL bp_second: got vo=%b data=%h expected 1 1616..16", bus.rnd_valid_out, bus.rnd_data_out);
    end
  endtask
  task automatic test_err();
    apply_reset();
    cyc();
    inj = 1;
    cyc();
    inj = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if ({bus.err_out, bus.rnd_valid_out, bus.key_valid_out} !== 3'b100) begin
        n_fail++; $display("FAIL err_sticky[%0d]: got err=%b rvo=%b kvo=%b expected 1 0 0", i, bus.err_out, bus.rnd_valid_out, bus.key_valid_out);
      end
      cyc();
    end
    apply_reset();
    #1;
    n_checks++;
    if (bus.err_out !== 1'b0) begin
      n_fail++; $display("FAIL err_clear: got %b expected 0", bus.err_out);
    end
  endtask
  task automatic test_reset_midflight();
    apply_reset();
    bus.rnd_ready_in = 0; bus.key_ready_in = 0;
    bus.rnd_valid_in = 1; bus.key_valid_in = 1;
    bus.rnd_data_in = '0; bus.key_data_in = '0;
    cyc();
    cyc();
    bus.rnd_valid_in = 0; bus.key_valid_in = 0;
    reset = 1;
    #1;
    n_checks++;
    if ({bus.rnd_valid_out, bus.key_valid_out, bus.busy_out, bus.sb_valid, bus.err_out} !== 5'b0 || bus.rnd_data_out !== '0) begin
      n_fail++; $display("FAIL rst_mid: got rvo=%b kvo=%b busy=%b sbv=%b err=%b rd=%h expected all 0", bus.rnd_valid_out, bus.key_valid_out, bus.busy_out, bus.sb_valid, bus.err_out, bus.rnd_data_out);
    end
    cyc();
    reset = 0;
    bus.rnd_ready_in = 1; bus.key_ready_in = 1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      n_checks++;
      if ({bus.rnd_valid_out, bus.key_valid_out, bus.err_out, bus.busy_out} !== 4'b0) begin
        n_fail++; $display("FAIL rst_after[%0d]: got rvo=%b kvo=%b err=%b busy=%b expected 0 0 0 0", i, bus.rnd_valid_out, bus.key_valid_out, bus.err_out, bus.busy_out);
      end
    end
  endtask
  initial begin
    test_reset();
    test_round_only();
    test_key_only();
    test_arbitration();
    test_backpressure();
    test_err();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/aes_subbytes_arbiter.md
# aes_subbytes_arbiter

Shares one 128-bit SubBytes unit between two requesters: the round datapath (full 128-bit state) and the key-expansion path (32-bit SubWord). Arbitrates round-robin, tags each issue through the SubBytes latency, and routes each result into a per-requester holding register with valid/ready output. Sits between the round controller, the key scheduler and the single SubBytes instance; the area of one 16-S-box array is paid once.

## Interface
- DATA_LEN, 128, state width, equal to the SubBytes data width
- WORD_LEN, 32, key-word width, carried in SubBytes bits [WORD_LEN-1:0]
- SBOX_LAT, 1, SubBytes latency in cycles, from sb_valid to sb_valid_ret; minimum 1
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- rnd_valid_in / rnd_ready_out  in / out  1 / 1  round-request handshake
- rnd_data_in  in  DATA_LEN  state to substitute
- rnd_valid_out / rnd_ready_in  out / in  1 / 1  round-result handshake
- rnd_data_out  out  DATA_LEN  substituted state
- key_valid_in / key_ready_out  in / out  1 / 1  key-request handshake
- key_data_in  in  WORD_LEN  word to substitute
- key_valid_out / key_ready_in  out / in  1 / 1  key-result handshake
- key_data_out  out  WORD_LEN  substituted word
- sb_valid  out  1  issue strobe to SubBytes
- sb_data  out  DATA_LEN  SubBytes input; for a key issue: {zeros, key_data_in}
- sb_valid_ret  in  1  SubBytes result valid
- sb_data_ret  in  DATA_LEN  SubBytes result
- busy_out  out  1  any request in flight or held
- err_out  out  1  sticky: sb_valid_ret seen with no matching tag

## Operation
- Per requester X, the `outX` flag marks an outstanding transaction, either in flight or held in the result register. It is set on accept and cleared on the output handshake.
- X is eligible when X_valid_in=1 and outX=0.
- Grant is combinational among eligible requesters. On a tie, grant the requester not in `last_grant`.
- `last_grant` updates on every accept. Its reset value is KEY, so the first tie goes to ROUND.
- X_ready_out=1 only when X is granted. Accept happens when X_valid_in && X_ready_out. At most one accept per cycle.
- On accept: sb_valid=1 and sb_data is the muxed input in the same cycle, and {valid=1, id=X} enters the tag delay line.
- With no accept: sb_valid=0 and sb_data=0.
- The tag delay line is SBOX_LAT stages deep. Its last stage is aligned with sb_valid_ret.
- On sb_valid_ret with a valid tag: capture sb_data_ret into the result register for tag id, and set X_valid_out. For KEY, capture only bits [WORD_LEN-1:0].
- On sb_valid_ret with no valid tag, or a valid tag with no sb_valid_ret: set err_out and discard the data. err_out clears only on reset.
- Output handshake: when X_valid_out && X_ready_in, clear X_valid_out and outX. X becomes eligible again the next cycle.
- X_data_out holds its value while X_valid_out=1 and X_ready_in=0.
- busy_out = outRND | outKEY.
- The SubBytes instance must share this reset, so no stale return survives a reset.

## Timing
- Reset values: all handshake outputs 0, sb_valid 0, sb_data 0, data outputs 0, busy_out 0, err_out 0, tags cleared, last_grant=KEY.
- Reset mid-operation drops in-flight and held results without error.
- Latency: accept in cycle T → sb_valid_ret in T+SBOX_LAT → X_valid_out=1 from T+SBOX_LAT+1.
- Single-requester throughput: one transaction per SBOX_LAT+2 cycles with ready_in tied high.
- Two requesters: issues interleave, and both can be in flight at once in different tag stages.
- Simultaneous requests from both at reset: ROUND is accepted at T, KEY at T+1.
- Backpressure on X does not block the other requester.
- A request held while outX=1 stays pending: ready_out=0 and the input is not sampled.

## Structure
- Put these in the shared package aes_pkg:
  - DATA_LEN and WORD_LEN constants
  - requester id enum: REQ_RND=0, REQ_KEY=1
  - tag struct: {valid, id}
- Sub-module aes_sb_tag_pipe: parameterized SBOX_LAT shift register of tags with asynchronous active-high reset.
- The arbiter top holds the grant logic, the out flags and the two result registers. SubBytes is instantiated at the level above.

## Test plan
- ROUND only, data 0x00…00, ready_in=1 → rnd_data_out=0x6363…63, valid at accept+SBOX_LAT+1; busy_out falls the cycle after the handshake.
- KEY only, key_data_in=0x00530000 → sb_data upper 96 bits zero; key_data_out=0x63ED6363.
- Both valid in the first cycle after reset → ROUND accepted first, KEY next cycle. Then both valid again → KEY wins (round-robin), and last_grant alternates.
- rnd_ready_in=0 for 10 cycles after a result → rnd_data_out stable, rnd_ready_out=0, KEY transactions still complete.
- Inject sb_valid_ret with an empty tag pipe → err_out=1, sticky until reset, no valid_out asserted.
- Assert reset while both are in flight → all outputs 0 next cycle, no result emitted after release, err_out=0.
